// File: rtl/ram_slot_sched.sv
// Single-port main RAM time-slot scheduler: owns the 1 MHz phase counter and
// multiplexes CPU/VIC-II (PH1, PH2) and a host loader (idle HOST slots) onto one port.
//
// host state | meaning
// HS_IDLE    | no host access issued in the previous clock
// HS_RD      | host read issued last clock, RAM data valid now
// HS_WR      | host write issued last clock, completes now
module ram_slot_sched #(
    parameter int AW  = 16,
    parameter int DW  = 8,
    parameter int DIV = 8
) (
    input  logic          clk,
    input  logic          rst,
    output logic          o_ph1_en,
    output logic          o_ph2_en,
    input  logic          i_vic_bm,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic          i_cpu_we,
    input  logic [DW-1:0] i_cpu_do,
    input  logic [AW-1:0] i_vic_addr1,
    input  logic [AW-1:0] i_vic_addr2,
    output logic [DW-1:0] o_ph1_do,
    output logic [DW-1:0] o_ph2_do,
    input  logic          i_host_req,
    input  logic          i_host_we,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_di,
    output logic          o_host_ack,
    output logic [DW-1:0] o_host_do,
    output logic          o_ram_en,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_di,
    input  logic [DW-1:0] i_ram_do
);

    localparam int CW = $clog2(DIV);

    localparam logic [CW-1:0] C_PH1  = '0;
    localparam logic [CW-1:0] C_PH2  = CW'(DIV / 2);
    localparam logic [CW-1:0] C_HST1 = CW'(DIV / 4);
    localparam logic [CW-1:0] C_HST2 = CW'((3 * DIV) / 4);
    localparam logic [CW-1:0] C_CAP1 = CW'(1);
    localparam logic [CW-1:0] C_CAP2 = CW'((DIV / 2) + 1);

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_RD,
        HS_WR
    } host_st_t;

    logic [CW-1:0] c_q, c_d;
    host_st_t      hs_q, hs_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] di_q, di_d;
    logic [DW-1:0] ph1_do_q, ph1_do_d;
    logic [DW-1:0] ph2_do_q, ph2_do_d;
    logic [DW-1:0] host_do_q, host_do_d;
    logic          ack_q, ack_d;
    logic          slot_ph1, slot_ph2, slot_host, host_go;

    always_comb begin
        c_d       = c_q + CW'(1);
        slot_ph1  = !rst && (c_q == C_PH1);
        slot_ph2  = !rst && (c_q == C_PH2);
        slot_host = !rst && ((c_q == C_HST1) || (c_q == C_HST2));
        host_go   = slot_host && i_host_req;

        // Idle sub-cycles keep the last address/data on the bus.
        o_ram_en   = 1'b0;
        o_ram_we   = 1'b0;
        o_ram_addr = addr_q;
        o_ram_di   = di_q;
        if (rst) begin
            o_ram_addr = '0;
            o_ram_di   = '0;
        end else if (slot_ph1) begin
            o_ram_en = 1'b1;
            if (i_vic_bm) begin
                o_ram_we   = i_cpu_we;
                o_ram_addr = i_cpu_addr;
                o_ram_di   = i_cpu_do;
            end else begin
                o_ram_addr = i_vic_addr1;
            end
        end else if (slot_ph2) begin
            o_ram_en   = 1'b1;
            o_ram_addr = i_vic_addr2;
        end else if (host_go) begin
            o_ram_en   = 1'b1;
            o_ram_we   = i_host_we;
            o_ram_addr = i_host_addr;
            o_ram_di   = i_host_di;
        end

        addr_d = o_ram_addr;
        di_d   = o_ram_di;

        hs_d = HS_IDLE;
        if (host_go) begin
            hs_d = i_host_we ? HS_WR : HS_RD;
        end

        ack_d     = (hs_q != HS_IDLE);
        host_do_d = (hs_q == HS_RD) ? i_ram_do : host_do_q;
        ph1_do_d  = (c_q == C_CAP1) ? i_ram_do : ph1_do_q;
        ph2_do_d  = (c_q == C_CAP2) ? i_ram_do : ph2_do_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q       <= '0;
            hs_q      <= HS_IDLE;
            addr_q    <= '0;
            di_q      <= '0;
            ph1_do_q  <= '0;
            ph2_do_q  <= '0;
            host_do_q <= '0;
            ack_q     <= 1'b0;
        end else begin
            c_q       <= c_d;
            hs_q      <= hs_d;
            addr_q    <= addr_d;
            di_q      <= di_d;
            ph1_do_q  <= ph1_do_d;
            ph2_do_q  <= ph2_do_d;
            host_do_q <= host_do_d;
            ack_q     <= ack_d;
        end
    end

    assign o_ph1_en   = slot_ph1;
    assign o_ph2_en   = slot_ph2;
    assign o_ph1_do   = ph1_do_q;
    assign o_ph2_do   = ph2_do_q;
    assign o_host_ack = ack_q;
    assign o_host_do  = host_do_q;

endmodule

// File: tb/tb_ram_slot_sched.sv
// Directed bench for ram_slot_sched with a synchronous 64 KiB RAM model.
// Cycle index cyc counts clocks since reset release; the slot phase is cyc % 8.
module tb_ram_slot_sched;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int DIV = 8;

    logic          clk;
    logic          rst;
    logic          ph1_en, ph2_en;
    logic          vic_bm;
    logic [AW-1:0] cpu_addr;
    logic          cpu_we;
    logic [DW-1:0] cpu_do;
    logic [AW-1:0] vic_addr1, vic_addr2;
    logic [DW-1:0] ph1_do, ph2_do;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_di;
    logic          host_ack;
    logic [DW-1:0] host_do;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    ram_slot_sched #(.AW(AW), .DW(DW), .DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .o_ph1_en    (ph1_en),
        .o_ph2_en    (ph2_en),
        .i_vic_bm    (vic_bm),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_we    (cpu_we),
        .i_cpu_do    (cpu_do),
        .i_vic_addr1 (vic_addr1),
        .i_vic_addr2 (vic_addr2),
        .o_ph1_do    (ph1_do),
        .o_ph2_do    (ph2_do),
        .i_host_req  (host_req),
        .i_host_we   (host_we),
        .i_host_addr (host_addr),
        .i_host_di   (host_di),
        .o_host_ack  (host_ack),
        .o_host_do   (host_do),
        .o_ram_en    (ram_en),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_di    (ram_di),
        .i_ram_do    (ram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_di;
            ram_do <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto_c(input int k);
        for (int n = 0; n < DIV && (cyc % DIV) != k; n++) next_cyc();
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        ram_do    = '0;
        rst       = 1'b1;
        vic_bm    = 1'b1;
        cpu_addr  = '0;
        cpu_we    = 1'b0;
        cpu_do    = '0;
        vic_addr1 = '0;
        vic_addr2 = '0;
        host_req  = 1'b0;
        host_we   = 1'b0;
        host_addr = '0;
        host_di   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ph1_en", 32'(ph1_en), 32'd0);
        chk("rst_ph2_en", 32'(ph2_en), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ack", 32'(host_ack), 32'd0);
        chk("rst_ph1_do", 32'(ph1_do), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        #1;

        // 1: phase enables at 0,8,16 and 4,12
        for (int i = 0; i < 17; i++) begin
            chk("ph1_en_seq", 32'(ph1_en), 32'((i % 8) == 0));
            chk("ph2_en_seq", 32'(ph2_en), 32'((i % 8) == 4));
            if (i < 16) next_cyc();
        end

        // 2: CPU write 0400 <= 41, then read back
        goto_c(7);
        cpu_we   = 1'b1;
        cpu_addr = 16'h0400;
        cpu_do   = 8'h41;
        next_cyc();
        chk("cpu_wr_en", 32'(ram_en), 32'd1);
        chk("cpu_wr_we", 32'(ram_we), 32'd1);
        chk("cpu_wr_addr", 32'(ram_addr), 32'h0400);
        chk("cpu_wr_di", 32'(ram_di), 32'h41);
        next_cyc();
        chk("idle_en", 32'(ram_en), 32'd0);
        chk("idle_we", 32'(ram_we), 32'd0);
        chk("idle_addr_hold", 32'(ram_addr), 32'h0400);
        chk("idle_di_hold", 32'(ram_di), 32'h41);
        cpu_we    = 1'b0;
        vic_addr2 = 16'h0400;
        next_cyc();
        chk("ph1_do_wr_slot", 32'(ph1_do), 32'h00);
        goto_c(0);
        chk("cpu_rd_we", 32'(ram_we), 32'd0);
        chk("cpu_rd_addr", 32'(ram_addr), 32'h0400);
        goto_c(2);
        chk("ph1_do_read", 32'(ph1_do), 32'h41);
        goto_c(6);
        chk("ph2_do_read", 32'(ph2_do), 32'h41);

        // 3: VIC owns PH1, CPU write strobe ignored
        goto_c(3);
        vic_bm    = 1'b0;
        vic_addr1 = 16'h0400;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h0500;
        cpu_do    = 8'h77;
        goto_c(0);
        chk("vic_ph1_en", 32'(ram_en), 32'd1);
        chk("vic_ph1_we", 32'(ram_we), 32'd0);
        chk("vic_ph1_addr", 32'(ram_addr), 32'h0400);
        goto_c(2);
        vic_bm = 1'b1;
        cpu_we = 1'b0;
        goto_c(0);
        chk("cpu_rd_0500_addr", 32'(ram_addr), 32'h0500);
        goto_c(2);
        chk("no_cpu_wr_0500", 32'(ph1_do), 32'h00);
        cpu_addr = 16'h0400;

        // 4: host write 0801 <= A9, then read back with req held
        goto_c(1);
        host_req  = 1'b1;
        host_we   = 1'b1;
        host_addr = 16'h0801;
        host_di   = 8'hA9;
        next_cyc();
        chk("hwr_en", 32'(ram_en), 32'd1);
        chk("hwr_we", 32'(ram_we), 32'd1);
        chk("hwr_addr", 32'(ram_addr), 32'h0801);
        chk("hwr_di", 32'(ram_di), 32'hA9);
        chk("hwr_ack_early", 32'(host_ack), 32'd0);
        chk("cpu_ph1_do_kept", 32'(ph1_do), 32'h41);
        next_cyc();
        chk("hwr_ack_pre", 32'(host_ack), 32'd0);
        next_cyc();
        chk("hwr_ack", 32'(host_ack), 32'd1);
        chk("hwr_do_unchanged", 32'(host_do), 32'h00);
        host_we = 1'b0;
        next_cyc();
        chk("hwr_ack_single", 32'(host_ack), 32'd0);
        goto_c(6);
        chk("hrd_en", 32'(ram_en), 32'd1);
        chk("hrd_we", 32'(ram_we), 32'd0);
        chk("hrd_addr", 32'(ram_addr), 32'h0801);
        next_cyc();
        chk("hrd_ack_pre", 32'(host_ack), 32'd0);
        next_cyc();
        chk("hrd_ack", 32'(host_ack), 32'd1);
        chk("hrd_do", 32'(host_do), 32'hA9);
        chk("cpu_slot_addr", 32'(ram_addr), 32'h0400);
        chk("cpu_slot_we", 32'(ram_we), 32'd0);
        host_req = 1'b0;
        next_cyc();
        chk("hrd_ack_single", 32'(host_ack), 32'd0);
        next_cyc();
        chk("no_req_no_en", 32'(ram_en), 32'd0);

        // 5: request raised after a HOST slot waits for the next one
        goto_c(3);
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 16'h0400;
        next_cyc();
        next_cyc();
        chk("late_req_idle", 32'(ram_en), 32'd0);
        next_cyc();
        chk("late_req_en", 32'(ram_en), 32'd1);
        chk("late_req_addr", 32'(ram_addr), 32'h0400);
        next_cyc();
        chk("late_ack_pre", 32'(host_ack), 32'd0);
        next_cyc();
        chk("late_ack", 32'(host_ack), 32'd1);
        chk("late_do", 32'(host_do), 32'h41);
        host_req = 1'b0;

        // 6: reset during a serviced host slot
        goto_c(1);
        host_req  = 1'b1;
        host_addr = 16'h0801;
        next_cyc();
        chk("pre_rst_slot", 32'(ram_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_comb_en", 32'(ram_en), 32'd0);
        next_cyc();
        chk("rst_no_ack", 32'(host_ack), 32'd0);
        chk("rst_host_do", 32'(host_do), 32'h00);
        chk("rst_ph1_do_clr", 32'(ph1_do), 32'h00);
        chk("rst_ph2_do_clr", 32'(ph2_do), 32'h00);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0000);
        chk("rst_ph1_en_low", 32'(ph1_en), 32'd0);
        next_cyc();
        chk("rst_no_ack2", 32'(host_ack), 32'd0);
        rst      = 1'b0;
        host_req = 1'b0;
        cyc      = 0;
        #1;
        chk("rel_ph1_en", 32'(ph1_en), 32'd1);
        next_cyc();
        chk("rel_no_ack", 32'(host_ack), 32'd0);
        goto_c(4);
        chk("rel_ph2_en", 32'(ph2_en), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
